aes_round_key_store_256: RTL and testbench

Round-key buffer that sits directly downstream of the AES-256 key expander. On a load request it captures round keys 0 and 1 from the 256-bit cipher key, then absorbs the 13 expanded 128-bit round keys (2..14) streamed by the expander. It then serves any round key by index to the cipher/decipher round engine through a registered read port. It decouples the expander's one-shot stream from the round engine's random-order access, so decryption can read keys 14 down to 0.

---
 rtl/aes_round_key_store_256.sv | 125 ++++++++++++
 tb/tb_aes_round_key_store_256.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_key_store_256.sv
// aes_round_key_store_256
//
// Round-key buffer placed directly downstream of the AES-256 key expander.
// A load request captures round keys 0 and 1 from the 256-bit cipher key.
// The buffer then absorbs round keys 2..NR, which the expander streams in
// order. After that, any round key can be read by index through a
// registered read port. This lets the round engine access keys in any
// order, including NR down to 0 for decryption.
//
// Ports:
//   clk          clock
//   reset        synchronous, active-high reset
//   load_start   one-cycle pulse: begin a new key load (any state)
//   cipher_key   256-bit cipher key, sampled on load_start
//   exp_valid    expander beat valid
//   exp_key      expanded round key, arriving in order 2..NR
//   busy         fill in progress
//   keys_ready   all NR+1 keys stored and readable
//   err_overflow sticky: exp_valid seen outside FILL
//   rd_en        read request
//   rd_round     round index to read
//   rd_key       registered read data (holds its value when no read is accepted)
//   rd_valid     rd_key updated by a read accepted on the previous edge

module aes_round_key_store_256 #(
    parameter int NR = 14,
    parameter int KW = 128
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_start,
    input  logic [2*KW-1:0] cipher_key,
    input  logic            exp_valid,
    input  logic [KW-1:0]   exp_key,
    output logic            busy,
    output logic            keys_ready,
    output logic            err_overflow,
    input  logic            rd_en,
    input  logic [3:0]      rd_round,
    output logic [KW-1:0]   rd_key,
    output logic            rd_valid
);

    localparam logic [3:0] LAST_IDX = 4'(NR);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_READY = 2'd2
    } state_t;

    state_t        state_r;
    logic [3:0]    wr_ptr_r;
    logic [KW-1:0] key_mem_r [0:NR];
    logic          rd_accept_s;

    // A read is served only once the full key schedule is stored and the index is in range.
    always_comb begin
        rd_accept_s = 1'b0;
        if (rd_en && keys_ready && (rd_round <= LAST_IDX)) begin
            rd_accept_s = 1'b1;
        end else begin
            rd_accept_s = 1'b0;
        end
    end

    // Fill FSM: key capture, expander beat absorption, and the status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            wr_ptr_r     <= 4'd0;
            busy         <= 1'b0;
            keys_ready   <= 1'b0;
            err_overflow <= 1'b0;
            for (int i = 0; i <= NR; i++) begin
                key_mem_r[i] <= {KW{1'b0}};
            end
        end else if (load_start) begin
            // load_start wins over a coincident beat; that beat is dropped silently.
            key_mem_r[0] <= cipher_key[2*KW-1:KW];
            key_mem_r[1] <= cipher_key[KW-1:0];
            wr_ptr_r     <= 4'd2;
            busy         <= 1'b1;
            keys_ready   <= 1'b0;
            err_overflow <= 1'b0;
            state_r      <= ST_FILL;
        end else if (exp_valid) begin
            case (state_r)
                ST_FILL: begin
                    key_mem_r[wr_ptr_r] <= exp_key;
                    wr_ptr_r            <= wr_ptr_r + 4'd1;
                    if (wr_ptr_r == LAST_IDX) begin
                        busy       <= 1'b0;
                        keys_ready <= 1'b1;
                        state_r    <= ST_READY;
                    end
                end
                ST_IDLE, ST_READY: begin
                    // The expander should be silent here; keep the data out and flag it.
                    err_overflow <= 1'b1;
                end
                default: begin
                    state_r      <= ST_IDLE;
                    busy         <= 1'b0;
                    keys_ready   <= 1'b0;
                    err_overflow <= 1'b1;
                end
            endcase
        end
    end

    // Registered read port; reads see the storage as it was before the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_key   <= {KW{1'b0}};
            rd_valid <= 1'b0;
        end else if (rd_accept_s) begin
            rd_key   <= key_mem_r[rd_round];
            rd_valid <= 1'b1;
        end else begin
            rd_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_aes_round_key_store_256.sv
module tb_aes_round_key_store_256;

    logic         clk;
    logic         reset;
    logic         load_start;
    logic [255:0] cipher_key;
    logic         exp_valid;
    logic [127:0] exp_key;
    logic         busy;
    logic         keys_ready;
    logic         err_overflow;
    logic         rd_en;
    logic [3:0]   rd_round;
    logic [127:0] rd_key;
    logic         rd_valid;

    aes_round_key_store_256 #(.NR(14), .KW(128)) dut (
        .clk          (clk),
        .reset        (reset),
        .load_start   (load_start),
        .cipher_key   (cipher_key),
        .exp_valid    (exp_valid),
        .exp_key      (exp_key),
        .busy         (busy),
        .keys_ready   (keys_ready),
        .err_overflow (err_overflow),
        .rd_en        (rd_en),
        .rd_round     (rd_round),
        .rd_key       (rd_key),
        .rd_valid     (rd_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // FIPS-197 C.3 AES-256 key schedule, round keys 0..14.
    logic [127:0] fips_rk [0:14];
    initial begin
        fips_rk[0]  = 128'h000102030405060708090a0b0c0d0e0f;
        fips_rk[1]  = 128'h101112131415161718191a1b1c1d1e1f;
        fips_rk[2]  = 128'ha573c29fa176c498a97fce93a572c09c;
        fips_rk[3]  = 128'h1651a8cd0244beda1a5da4c10640bade;
        fips_rk[4]  = 128'hae87dff00ff11b68a68ed5fb03fc1567;
        fips_rk[5]  = 128'h6de1f1486fa54f9275f8eb5373b8518d;
        fips_rk[6]  = 128'hc656827fc9a799176f294cec6cd5598b;
        fips_rk[7]  = 128'h3de23a75524775e727bf9eb45407cf39;
        fips_rk[8]  = 128'h0bdc905fc27b0948ad5245a4c1871c2f;
        fips_rk[9]  = 128'h45f5a66017b2d387300d4d33640a820a;
        fips_rk[10] = 128'h7ccff71cbeb4fe5413e6bbf0d261a7df;
        fips_rk[11] = 128'hf01afafee7a82979d7a5644ab3afe640;
        fips_rk[12] = 128'h2541fe719bf500258813bbd55a721c0a;
        fips_rk[13] = 128'h4e5a6699a9f24fe07e572baacdf8cdea;
        fips_rk[14] = 128'h24fc79ccbf0979e9371ac23c6d68de36;
    end

    localparam logic [255:0] KEY_A = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] ALT_MASK = {16{8'ha5}};

    // Reference model of the stored keys and the readable flag.
    logic [127:0] mdl_key [0:14];
    int           mdl_ptr;
    bit           mdl_fill;
    bit           mdl_ready;

    logic [127:0] sb_q [$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every rd_valid pulse must match the oldest expected read result.
    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL rd_unexpected: got rd_valid=1 key %h expected no read result", rd_key);
            end else begin
                chk("rd_key", rd_key, sb_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model the read-acceptance rule using the pre-edge ready flag.
    task automatic push_read(input logic [3:0] r);
        if (mdl_ready && r <= 4'd14) sb_q.push_back(mdl_key[r]);
    endtask

    task automatic load(input logic [255:0] k, input bit with_beat);
        load_start = 1'b1;
        cipher_key = k;
        exp_valid  = with_beat;
        exp_key    = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
        tick();
        load_start = 1'b0;
        exp_valid  = 1'b0;
        mdl_key[0] = k[255:128];
        mdl_key[1] = k[127:0];
        mdl_ptr    = 2;
        mdl_fill   = 1'b1;
        mdl_ready  = 1'b0;
    endtask

    task automatic beat(input logic [127:0] k);
        exp_valid = 1'b1;
        exp_key   = k;
        tick();
        exp_valid = 1'b0;
        if (mdl_fill) begin
            mdl_key[mdl_ptr] = k;
            mdl_ptr++;
            if (mdl_ptr == 15) begin
                mdl_fill  = 1'b0;
                mdl_ready = 1'b1;
            end
        end
    endtask

    task automatic rd(input logic [3:0] r);
        rd_en    = 1'b1;
        rd_round = r;
        push_read(r);
        tick();
        rd_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1; load_start = 1'b0; cipher_key = '0; exp_valid = 1'b0;
        exp_key = '0; rd_en = 1'b0; rd_round = 4'd0;
        mdl_ptr = 0; mdl_fill = 1'b0; mdl_ready = 1'b0;
        for (int i = 0; i < 15; i++) mdl_key[i] = '0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_busy", {127'd0, busy}, 128'd0);
        chk("rst_ready", {127'd0, keys_ready}, 128'd0);
        chk("rst_err", {127'd0, err_overflow}, 128'd0);
        chk("rst_rdv", {127'd0, rd_valid}, 128'd0);
        chk("rst_rdkey", rd_key, 128'd0);

        // Normal back-to-back fill with the FIPS key.
        load(KEY_A, 1'b0);
        chk("fill_busy0", {127'd0, busy}, 128'd1);
        for (int i = 2; i <= 14; i++) begin
            beat(fips_rk[i]);
            chk("fill_busy", {127'd0, busy}, (i < 14) ? 128'd1 : 128'd0);
            chk("fill_ready", {127'd0, keys_ready}, (i < 14) ? 128'd0 : 128'd1);
        end
        rd(4'd0); tick();
        rd(4'd1); tick();
        rd(4'd14);
        chk("rd14_valid", {127'd0, rd_valid}, 128'd1);
        chk("rd14_fips", rd_key, 128'h24fc79ccbf0979e9371ac23c6d68de36);
        tick();
        chk("rd_idle_valid", {127'd0, rd_valid}, 128'd0);

        // Reverse reads 14..0 back to back, then an out-of-range index.
        for (int r = 14; r >= 0; r--) rd(4'(r));
        rd(4'd15);
        chk("rd15_valid", {127'd0, rd_valid}, 128'd0);
        chk("rd15_hold", rd_key, fips_rk[0]);

        // Extra beat once READY: flagged, storage untouched.
        beat(128'h0123456789abcdef0123456789abcdef);
        chk("ovf_err", {127'd0, err_overflow}, 128'd1);
        rd(4'd14); tick();

        // Gapped fill with a second key, reading while the fill is in progress.
        load(~KEY_A, 1'b0);
        chk("gap_err_clr", {127'd0, err_overflow}, 128'd0);
        for (int i = 2; i <= 14; i++) begin
            beat(fips_rk[i] ^ ALT_MASK);
            if (i < 14) begin
                chk("gap_ready", {127'd0, keys_ready}, 128'd0);
                rd(4'(i));
                chk("gap_rdv", {127'd0, rd_valid}, 128'd0);
                tick();
            end else begin
                chk("gap_ready_end", {127'd0, keys_ready}, 128'd1);
            end
        end
        rd(4'd1); rd(4'd2); rd(4'd14);

        // Read coincident with load_start still returns the old entry 0.
        rd_en = 1'b1; rd_round = 4'd0; push_read(4'd0);
        load(KEY_A, 1'b0);
        rd_en = 1'b0;
        chk("ld_rd_ready", {127'd0, keys_ready}, 128'd0);

        // Mid-fill reload with a coincident beat: beat discarded, pointer restarts at 2.
        for (int i = 2; i <= 5; i++) beat(fips_rk[i]);
        load(~KEY_A, 1'b1);
        chk("reload_err", {127'd0, err_overflow}, 128'd0);
        chk("reload_busy", {127'd0, busy}, 128'd1);
        for (int i = 2; i <= 14; i++) beat(fips_rk[i] ^ ALT_MASK);
        chk("reload_ready", {127'd0, keys_ready}, 128'd1);
        rd(4'd0); rd(4'd2); rd(4'd5); rd(4'd14); tick();

        // Reset mid-fill.
        load(KEY_A, 1'b0);
        for (int i = 2; i <= 6; i++) beat(fips_rk[i]);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mdl_fill = 1'b0; mdl_ready = 1'b0;
        chk("mrst_busy", {127'd0, busy}, 128'd0);
        chk("mrst_ready", {127'd0, keys_ready}, 128'd0);
        chk("mrst_rdkey", rd_key, 128'd0);
        rd(4'd0);
        chk("mrst_rdv", {127'd0, rd_valid}, 128'd0);
        tick(); tick();

        chk("sb_drain", 128'(sb_q.size()), 128'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
